sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-requester arbiter in front of the single sram_controller word port. It shares the external SRAM between port 0 (LSU data path) and port 1 (secondary master, e.g. instruction fetch or DMA). It grants one transaction at a time, holds the controller strobes until the controller acks, and routes the response back to the granted port. A timeout guard returns an error if the controller never acks.

Parameters:
ADDR_W, 18, byte-address width driven to the controller
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins a simultaneous request
TIMEOUT, 255, maximum BUSY cycles without i_mem_ack before an error response (must be >= 2)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req0 / i_req1  in  1  transaction request, per port
i_we0 / i_we1  in  1  1 = write, 0 = read
i_addr0 / i_addr1  in  ADDR_W  byte address
i_wdata0 / i_wdata1  in  32  write data
i_bmask0 / i_bmask1  in  4  byte-lane enables
o_ack0 / o_ack1  out  1  one-cycle completion pulse
o_err0 / o_err1  out  1  timeout flag, valid with ack
o_rdata0 / o_rdata1  out  32  read data, valid with ack
o_mem_addr  out  ADDR_W  to controller i_ADDR
o_mem_wdata  out  32  to controller i_WDATA
o_mem_bmask  out  4  to controller i_BMASK
o_mem_wren  out  1  to controller i_WREN
o_mem_rden  out  1  to controller i_RDEN
i_mem_rdata  in  32  from controller o_RDATA
i_mem_ack  in  1  from controller o_ACK
o_busy  out  1  high in BUSY or RESP
o_grant  out  2  one-hot granted port, 00 when IDLE

Behaviour:
- Reset (async, immediate):
  - State = IDLE; all outputs 0, including o_mem_wren/o_mem_rden.
  - RR pointer = "port 1 last granted", so port 0 wins the first tie.
  - Timeout counter = 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- IDLE:
  - If any i_req is high, pick the winner:
    - Only one requesting: that port.
    - Both requesting, FIXED_PRIO=1: port 0.
    - Both requesting, FIXED_PRIO=0: the port not last granted.
  - Latch the winner's we/addr/wdata/bmask, set o_grant, update the RR pointer, go to BUSY.
- BUSY:
  - o_mem_wren = latched we; o_mem_rden = ~latched we.
  - addr, wdata and bmask are held constant; the counter increments each cycle.
  - If i_mem_ack is high: capture i_mem_rdata, deassert both strobes on the next edge, go to RESP with err=0.
  - Otherwise, if the counter reaches TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - If ack and timeout occur in the same cycle, ack wins (err=0).
- RESP (exactly one cycle):
  - o_ackN = 1 for the granted port only.
  - o_errN as resolved in BUSY.
  - o_rdataN is updated only for reads or timeouts; writes leave o_rdataN unchanged.
  - Strobes are 0. Next state IDLE; the counter clears.
- Timing:
  - Request seen in IDLE at cycle 0 → strobes first high at cycle 1.
  - Controller ack at cycle n → o_ack at cycle n+1 → IDLE at n+2.
  - Minimum spacing from one grant to the next is 3 cycles.
- Requester rules:
  - Hold req and all fields stable until ack.
  - Deassert req at the edge that ends the ack cycle.
  - A req still high in IDLE after that edge is a new request.
- Field changes in BUSY are ignored, because the fields were latched.
- i_mem_ack in IDLE or RESP is ignored and must not generate any response.
- o_rdataN and o_errN hold their values between acks; o_errN is cleared on the next ack to that port.
- The losing requester's req stays pending and is served on the next IDLE; it never times out in this block.
- Address/bmask legality is not checked; values pass through unchanged.

Test Plan:
- Single read, port 0: addr=0x00104, controller acks 3 cycles after rden rises with rdata=0xDEADBEEF → o_ack0 one cycle with o_rdata0=0xDEADBEEF, o_err0=0, o_ack1 never pulses.
- Single write, port 1: wdata=0x12345678, bmask=0011 → o_mem_wren=1, o_mem_rden=0, addr/wdata/bmask stable until ack; o_ack1 pulses; o_rdata1 unchanged.
- Simultaneous continuous requests, FIXED_PRIO=0: grants alternate 0,1,0,1 over 4 transactions. With FIXED_PRIO=1, port 0 is granted every time while requesting, and port 1 is served only when port 0 is idle.
- Timeout, TIMEOUT=8, no i_mem_ack: strobes drop after 8 BUSY cycles; o_ack0=1, o_err0=1, o_rdata0=0. Next transaction completes normally with err=0.
- Ack coinciding with final timeout cycle → err=0, rdata captured. Spurious i_mem_ack in IDLE → no o_ack.
- i_rst_n asserted mid-BUSY → strobes, o_busy and o_grant go 0 immediately without a clock. After release, a tie goes to port 0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles everything between the two requesters, the arbiter and the
// sram_controller word port. Clock and reset stay outside the bundle.
//
// Requester side (per port N = 0/1):
//   i_reqN, i_weN, i_addrN, i_wdataN, i_bmaskN   -> arbiter
//   o_ackN, o_errN, o_rdataN                     <- arbiter
// Controller side:
//   o_mem_addr, o_mem_wdata, o_mem_bmask,
//   o_mem_wren, o_mem_rden                       -> controller
//   i_mem_rdata, i_mem_ack                       <- controller
// Status:
//   o_busy (BUSY or RESP), o_grant (one-hot granted port)
//
// Modports: slave = the arbiter's view, master = whoever drives the
// requester and controller inputs (the system, or a testbench).
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int ADDR_W = 18
) ();
    logic              i_req0;
    logic              i_req1;
    logic              i_we0;
    logic              i_we1;
    logic [ADDR_W-1:0] i_addr0;
    logic [ADDR_W-1:0] i_addr1;
    logic [31:0]       i_wdata0;
    logic [31:0]       i_wdata1;
    logic [3:0]        i_bmask0;
    logic [3:0]        i_bmask1;
    logic              o_ack0;
    logic              o_ack1;
    logic              o_err0;
    logic              o_err1;
    logic [31:0]       o_rdata0;
    logic [31:0]       o_rdata1;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              o_mem_wren;
    logic              o_mem_rden;
    logic [31:0]       i_mem_rdata;
    logic              i_mem_ack;
    logic              o_busy;
    logic [1:0]        o_grant;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
               i_wdata0, i_wdata1, i_bmask0, i_bmask1,
               i_mem_rdata, i_mem_ack,
        output o_ack0, o_ack1, o_err0, o_err1, o_rdata0, o_rdata1,
               o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden,
               o_busy, o_grant
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
               i_wdata0, i_wdata1, i_bmask0, i_bmask1,
               i_mem_rdata, i_mem_ack,
        input  o_ack0, o_ack1, o_err0, o_err1, o_rdata0, o_rdata1,
               o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden,
               o_busy, o_grant
    );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares the single sram_controller word port between port 0 (LSU) and
// port 1 (fetch/DMA). One transaction at a time: the winner's fields are
// latched, the controller strobes are held until the controller acks, and
// a one-cycle ack (with error flag and read data) goes back to the winner.
// If the controller never acks, the transaction ends after TIMEOUT busy
// cycles with err=1 and rdata=0.
//
// Parameters:
//   ADDR_W     byte-address width
//   FIXED_PRIO 0 = round-robin on ties, 1 = port 0 always wins ties
//   TIMEOUT    busy cycles without ack before an error response (>= 2)
// Ports:
//   i_clk      clock, all state on the rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        sram_arbiter_if.slave (requesters, controller, status)
// All outputs are registered.
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    sram_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  busy_cnt;
    logic              last_was_1;
    logic              pick_1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_bmask;
    logic              finish;

    // Winner selection for the IDLE cycle. A lone requester always wins.
    // On a tie, fixed priority favours port 0; round-robin favours the port
    // that was not granted last (last_was_1 resets to 1 so port 0 wins the
    // first tie after reset).
    always_comb begin
        pick_1 = bus.i_req1;
        if (bus.i_req0 && bus.i_req1) begin
            pick_1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_was_1;
        end
    end

    // Mux out the winning port's transaction fields so the state machine
    // can latch them in one place.
    always_comb begin
        sel_we    = pick_1 ? bus.i_we1    : bus.i_we0;
        sel_addr  = pick_1 ? bus.i_addr1  : bus.i_addr0;
        sel_wdata = pick_1 ? bus.i_wdata1 : bus.i_wdata0;
        sel_bmask = pick_1 ? bus.i_bmask1 : bus.i_bmask0;
    end

    // A busy transaction ends on a controller ack or on the last allowed
    // busy cycle. When both happen together the ack wins, which is why the
    // error flag below is derived from the ack alone.
    always_comb begin
        finish = bus.i_mem_ack || (busy_cnt == CNT_LAST);
    end

    // Main state machine; every output is a register written here.
    // The granted port is read back from o_grant[1] and the read/write
    // direction from o_mem_rden, both of which are stable through BUSY,
    // so no separate copies of them are kept.
    // Writes leave the port's rdata untouched; reads take the controller
    // data; timeouts force rdata to zero regardless of direction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            busy_cnt        <= '0;
            last_was_1      <= 1'b1;
            bus.o_ack0      <= 1'b0;
            bus.o_ack1      <= 1'b0;
            bus.o_err0      <= 1'b0;
            bus.o_err1      <= 1'b0;
            bus.o_rdata0    <= '0;
            bus.o_rdata1    <= '0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_mem_bmask <= '0;
            bus.o_mem_wren  <= 1'b0;
            bus.o_mem_rden  <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_grant     <= 2'b00;
        end else begin
            bus.o_ack0 <= 1'b0;
            bus.o_ack1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_req0 || bus.i_req1) begin
                        last_was_1      <= pick_1;
                        bus.o_mem_addr  <= sel_addr;
                        bus.o_mem_wdata <= sel_wdata;
                        bus.o_mem_bmask <= sel_bmask;
                        bus.o_mem_wren  <= sel_we;
                        bus.o_mem_rden  <= ~sel_we;
                        bus.o_grant     <= pick_1 ? 2'b10 : 2'b01;
                        bus.o_busy      <= 1'b1;
                        busy_cnt        <= '0;
                        state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        bus.o_mem_wren <= 1'b0;
                        bus.o_mem_rden <= 1'b0;
                        state          <= ST_RESP;
                        if (bus.o_grant[1]) begin
                            bus.o_ack1 <= 1'b1;
                            bus.o_err1 <= ~bus.i_mem_ack;
                            if (!bus.i_mem_ack) begin
                                bus.o_rdata1 <= '0;
                            end else if (bus.o_mem_rden) begin
                                bus.o_rdata1 <= bus.i_mem_rdata;
                            end
                        end else begin
                            bus.o_ack0 <= 1'b1;
                            bus.o_err0 <= ~bus.i_mem_ack;
                            if (!bus.i_mem_ack) begin
                                bus.o_rdata0 <= '0;
                            end else if (bus.o_mem_rden) begin
                                bus.o_rdata0 <= bus.i_mem_rdata;
                            end
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    busy_cnt    <= '0;
                    bus.o_busy  <= 1'b0;
                    bus.o_grant <= 2'b00;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Two arbiters side by side (index 0 round-robin, index 1 fixed priority),
// both with TIMEOUT=8, each fed by two random requesters and a random
// controller (random ack latency, some never-ack timeouts, ack on the last
// busy cycle, spurious acks while not busy). A transaction-level model
// predicts each grant from the request lines, checks the controller bus
// while busy, and pushes the expected response into a queue; a monitor pops
// and compares whenever an o_ack appears. A mid-BUSY reset checks that the
// outputs clear without a clock and that the following tie goes to port 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int ADDR_W   = 18;
    localparam int TMO      = 8;
    localparam int N_CYCLES = 3000;

    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    bit         stim_en = 1'b0;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         pending [2];
    logic [4:0] mon_st [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam bit FP = (g == 1);

        sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

        sram_arbiter #(
            .ADDR_W    (ADDR_W),
            .FIXED_PRIO(g),
            .TIMEOUT   (TMO)
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .bus    (bus)
        );

        assign mon_st[g] = {bus.o_mem_wren, bus.o_mem_rden, bus.o_busy, bus.o_grant};

        bit              act [2];
        bit              ack_seen [2];
        int              gap [2];
        logic            we_d [2];
        logic [ADDR_W-1:0] addr_d [2];
        logic [31:0]     wdata_d [2];
        logic [3:0]      bmask_d [2];

        task automatic apply_stimulus(input int p);
            act[p]      = 1'b1;
            ack_seen[p] = 1'b0;
            we_d[p]     = 1'($urandom_range(0, 1));
            addr_d[p]   = ADDR_W'($urandom);
            wdata_d[p]  = $urandom;
            bmask_d[p]  = 4'($urandom_range(0, 15));
        endtask

        // Requesters: hold a transaction until its ack has been seen, then
        // drop req (or present a fresh transaction) on the following edge.
        // While reset is held both ports are made to request, so the first
        // decision after reset is always a tie.
        always @(posedge clk) begin
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) begin
                    if (!act[p]) apply_stimulus(p);
                    ack_seen[p] = 1'b0;
                end else if (act[p]) begin
                    if (ack_seen[p]) begin
                        act[p] = 1'b0;
                        gap[p] = $urandom_range(0, 3);
                        if (stim_en && gap[p] == 0) apply_stimulus(p);
                    end else if ((p == 0) ? bus.o_ack0 : bus.o_ack1) begin
                        ack_seen[p] = 1'b1;
                    end
                end else if (stim_en) begin
                    if (gap[p] == 0) apply_stimulus(p);
                    else gap[p]--;
                end
            end
            bus.i_req0   = act[0];
            bus.i_we0    = we_d[0];
            bus.i_addr0  = addr_d[0];
            bus.i_wdata0 = wdata_d[0];
            bus.i_bmask0 = bmask_d[0];
            bus.i_req1   = act[1];
            bus.i_we1    = we_d[1];
            bus.i_addr1  = addr_d[1];
            bus.i_wdata1 = wdata_d[1];
            bus.i_bmask1 = bmask_d[1];
        end

        int ck  = 0;
        int lat = 0;

        // Controller: picks an ack latency when strobes rise; latencies of
        // TMO and above never ack. Occasionally acks while not strobed.
        always @(posedge clk) begin
            #1;
            bus.i_mem_rdata = $urandom;
            if (bus.o_mem_wren || bus.o_mem_rden) begin
                if (ck == 0) lat = $urandom_range(0, TMO + 1);
                bus.i_mem_ack = (ck == lat);
                ck++;
            end else begin
                ck = 0;
                bus.i_mem_ack = ($urandom_range(0, 7) == 0);
            end
        end

        exp_t        exp_q [$];
        exp_t        e;
        int          cur = -1;
        int          start = 0;
        int          free_cyc = 0;
        int          resp_port = 0;
        int          k;
        int          p;
        int          o;
        bit          last1_m = 1'b1;
        logic        s_we;
        logic [ADDR_W-1:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_bmask;
        logic [31:0] mrd [2];
        logic        merr [2];
        logic        err_n;
        logic [31:0] rd_n;

        // Reference model and response monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (!rst_n) begin
                check_output("rst_ctrl", {bus.o_ack0, bus.o_ack1, bus.o_err0, bus.o_err1,
                                          bus.o_mem_wren, bus.o_mem_rden, bus.o_busy,
                                          bus.o_grant, bus.o_mem_bmask}, 64'd0);
                check_output("rst_rdata", {bus.o_rdata0, bus.o_rdata1}, 64'd0);
                check_output("rst_membus", {bus.o_mem_addr, bus.o_mem_wdata}, 64'd0);
                cur      = -1;
                free_cyc = 0;
                last1_m  = 1'b1;
                exp_q.delete();
                mrd      = '{32'd0, 32'd0};
                merr     = '{1'b0, 1'b0};
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    check_output("ack_missing", 64'd0, 64'd1);
                    void'(exp_q.pop_front());
                end
                if (bus.o_ack0 || bus.o_ack1) begin
                    if (exp_q.size() == 0) begin
                        check_output("spurious_ack", {bus.o_ack1, bus.o_ack0}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        o = 1 - e.port;
                        check_output("ack_cycle", cyc, e.due);
                        check_output("ack_port", {bus.o_ack1, bus.o_ack0}, (e.port == 1) ? 2'b10 : 2'b01);
                        check_output("ack_err", (e.port == 1) ? bus.o_err1 : bus.o_err0, e.err);
                        check_output("ack_rdata", (e.port == 1) ? bus.o_rdata1 : bus.o_rdata0, e.rd);
                        check_output("hold_err", (o == 1) ? bus.o_err1 : bus.o_err0, merr[o]);
                        check_output("hold_rdata", (o == 1) ? bus.o_rdata1 : bus.o_rdata0, mrd[o]);
                    end
                end

                if (cur >= 0) begin
                    k = cyc - start;
                    check_output("busy_ctrl", {bus.o_mem_wren, bus.o_mem_rden, bus.o_busy, bus.o_grant},
                                 {s_we, ~s_we, 1'b1, (cur == 1) ? 2'b10 : 2'b01});
                    check_output("busy_addr", bus.o_mem_addr, s_addr);
                    check_output("busy_wdata", {bus.o_mem_wdata, bus.o_mem_bmask}, {s_wdata, s_bmask});
                    if (bus.i_mem_ack || k == TMO - 1) begin
                        err_n = ~bus.i_mem_ack;
                        rd_n  = err_n ? 32'd0 : (s_we ? mrd[cur] : bus.i_mem_rdata);
                        mrd[cur]  = rd_n;
                        merr[cur] = err_n;
                        exp_q.push_back('{due: cyc + 1, port: cur, err: err_n, rd: rd_n});
                        resp_port = cur;
                        free_cyc  = cyc + 2;
                        cur       = -1;
                    end
                end else if (cyc < free_cyc) begin
                    check_output("resp_ctrl", {bus.o_mem_wren, bus.o_mem_rden, bus.o_busy, bus.o_grant},
                                 {2'b00, 1'b1, (resp_port == 1) ? 2'b10 : 2'b01});
                end else begin
                    check_output("idle_ctrl", {bus.o_mem_wren, bus.o_mem_rden, bus.o_busy, bus.o_grant}, 64'd0);
                    if (bus.i_req0 || bus.i_req1) begin
                        if (bus.i_req0 && bus.i_req1) p = FP ? 0 : (last1_m ? 0 : 1);
                        else p = bus.i_req1 ? 1 : 0;
                        last1_m = (p == 1);
                        s_we    = (p == 1) ? bus.i_we1    : bus.i_we0;
                        s_addr  = (p == 1) ? bus.i_addr1  : bus.i_addr0;
                        s_wdata = (p == 1) ? bus.i_wdata1 : bus.i_wdata0;
                        s_bmask = (p == 1) ? bus.i_bmask1 : bus.i_bmask0;
                        cur     = p;
                        start   = cyc + 1;
                    end
                end
            end
            pending[g] = exp_q.size();
        end
    end

    int waited;

    // Phases: reset, random traffic, reset in the middle of a busy
    // transaction, drain, final queue check and summary.
    initial begin
        rst_n   = 1'b0;
        stim_en = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n   = 1'b1;
        stim_en = 1'b1;
        repeat (N_CYCLES) @(posedge clk);

        waited = 0;
        do begin
            @(posedge clk);
            #2;
            waited++;
        end while (mon_st[0][4:3] == 2'b00 && waited < 200);
        if (mon_st[0][4:3] == 2'b00) check_output("wait_busy", 64'd0, 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_rr", mon_st[0], 64'd0);
        check_output("async_rst_fp", mon_st[1], 64'd0);
        stim_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_output("drain_rr", pending[0], 64'd0);
        check_output("drain_fp", pending[1], 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
